// File: rtl/fcpu_pkg.sv
// Shared fcpu definitions: global-memory bus widths and the burst master FSM state type.
package fcpu_pkg;

  localparam int GMEM_ADDR_W = 32;
  localparam int GMEM_DATA_W = 64;
  localparam int ID_WIDTH    = 4;

  typedef enum logic [2:0] {
    GM_IDLE  = 3'd0,
    GM_AR    = 3'd1,
    GM_RDATA = 3'd2,
    GM_AW    = 3'd3,
    GM_WDATA = 3'd4,
    GM_BRESP = 3'd5
  } gmem_mst_st_t;

endpackage

// File: rtl/gmem_burst_master.sv
// Single-outstanding AXI burst master bridging a simple command/stream interface to global memory.
// Define GMEM_MASTER_TIMEOUT_EN to build in the response watchdog.
module gmem_burst_master
  import fcpu_pkg::*;
#(
  parameter logic [GMEM_ADDR_W-1:0] ADDR_OFFSET = 32'h1000_0000,
  parameter logic [ID_WIDTH-1:0]    MST_ID      = {ID_WIDTH{1'b0}},
  parameter int                     TIMEOUT_W   = 10
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [GMEM_ADDR_W-1:0]   req_addr,
  input  logic [7:0]               req_len,
  input  logic [GMEM_DATA_W-1:0]   wd_data,
  input  logic [GMEM_DATA_W/8-1:0] wd_strb,
  input  logic                     wd_valid,
  output logic                     wd_ready,
  output logic [GMEM_DATA_W-1:0]   rd_data,
  output logic                     rd_last,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     done,
  output logic                     err,
  output logic [ID_WIDTH-1:0]      m0_arid,
  output logic [GMEM_ADDR_W-1:0]   m0_araddr,
  output logic [7:0]               m0_arlen,
  output logic [2:0]               m0_arsize,
  output logic [1:0]               m0_arburst,
  output logic                     m0_arvalid,
  input  logic                     m0_arready,
  input  logic [ID_WIDTH-1:0]      m0_rid,
  input  logic [GMEM_DATA_W-1:0]   m0_rdata,
  input  logic                     m0_rlast,
  input  logic                     m0_rvalid,
  output logic                     m0_rready,
  output logic [ID_WIDTH-1:0]      m0_awid,
  output logic [GMEM_ADDR_W-1:0]   m0_awaddr,
  output logic [7:0]               m0_awlen,
  output logic [2:0]               m0_awsize,
  output logic [1:0]               m0_awburst,
  output logic                     m0_awvalid,
  input  logic                     m0_awready,
  output logic [GMEM_DATA_W-1:0]   m0_wdata,
  output logic [GMEM_DATA_W/8-1:0] m0_wstrb,
  output logic                     m0_wlast,
  output logic                     m0_wvalid,
  input  logic                     m0_wready,
  input  logic [ID_WIDTH-1:0]      m0_bid,
  input  logic                     m0_bvalid,
  output logic                     m0_bready
);

  gmem_mst_st_t           state_q, state_d;
  logic [GMEM_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]             len_q, len_d;
  logic [7:0]             beat_q, beat_d;
  logic                   arvalid_q, arvalid_d;
  logic                   awvalid_q, awvalid_d;
  logic                   bready_q, bready_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic in_rd_s, in_wr_s, last_beat_s;
  logic ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s, any_hs_s;
  logic wd_fire_s;

  assign in_rd_s     = (state_q == GM_RDATA);
  assign in_wr_s     = (state_q == GM_WDATA);
  assign last_beat_s = (beat_q == len_q);

  assign ar_hs_s  = arvalid_q & m0_arready;
  assign r_hs_s   = in_rd_s & m0_rvalid & rd_ready;
  assign aw_hs_s  = awvalid_q & m0_awready;
  assign w_hs_s   = in_wr_s & wd_valid & m0_wready;
  assign b_hs_s   = bready_q & m0_bvalid;
  assign any_hs_s = ar_hs_s | r_hs_s | aw_hs_s | w_hs_s | b_hs_s;

  // Data phases are zero-latency pass-throughs gated by the registered state
  assign req_ready  = (state_q == GM_IDLE);
  assign rd_valid   = in_rd_s & m0_rvalid;
  assign rd_data    = m0_rdata;
  assign rd_last    = in_rd_s & m0_rlast;
  assign m0_rready  = in_rd_s & rd_ready;
  assign m0_wvalid  = in_wr_s & wd_valid;
  assign m0_wdata   = wd_data;
  assign m0_wstrb   = wd_strb;
  assign m0_wlast   = in_wr_s & last_beat_s;
  assign wd_ready   = in_wr_s & m0_wready;

  assign m0_arid    = MST_ID;
  assign m0_araddr  = addr_q;
  assign m0_arlen   = len_q;
  assign m0_arsize  = 3'd3;
  assign m0_arburst = 2'b01;
  assign m0_arvalid = arvalid_q;
  assign m0_awid    = MST_ID;
  assign m0_awaddr  = addr_q;
  assign m0_awlen   = len_q;
  assign m0_awsize  = 3'd3;
  assign m0_awburst = 2'b01;
  assign m0_awvalid = awvalid_q;
  assign m0_bready  = bready_q;
  assign done       = done_q;
  assign err        = err_q;

`ifdef GMEM_MASTER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;

  // Watchdog only runs while waiting on the slave; any handshake proves it alive
  always_comb begin
    wd_d = wd_q;
    if (any_hs_s || !(in_rd_s || (state_q == GM_BRESP))) begin
      wd_d = {TIMEOUT_W{1'b0}};
    end else if (!(&wd_q)) begin
      wd_d = wd_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end else begin
      wd_d = wd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      wd_q <= {TIMEOUT_W{1'b0}};
    end else begin
      wd_q <= wd_d;
    end
  end

  assign wd_fire_s = (&wd_q) & (in_rd_s | (state_q == GM_BRESP));
`else
  assign wd_fire_s = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    arvalid_d = arvalid_q;
    awvalid_d = awvalid_q;
    bready_d  = bready_q;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      GM_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr + ADDR_OFFSET;
          len_d  = req_len;
          beat_d = 8'd0;
          if (req_we) begin
            state_d   = GM_AW;
            awvalid_d = 1'b1;
          end else begin
            state_d   = GM_AR;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = GM_IDLE;
        end
      end
      GM_AR: begin
        if (ar_hs_s) begin
          state_d   = GM_RDATA;
          arvalid_d = 1'b0;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      GM_RDATA: begin
        if (r_hs_s) begin
          // rlast must coincide exactly with beat len and carry our ID
          if ((m0_rid != MST_ID) || (m0_rlast != last_beat_s)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (m0_rlast) begin
            state_d = GM_IDLE;
            done_d  = 1'b1;
          end else if (beat_q != 8'hFF) begin
            beat_d = beat_q + 8'd1;
          end else begin
            beat_d = beat_q;
          end
        end else if (wd_fire_s) begin
          err_d   = 1'b1;
          state_d = GM_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = GM_RDATA;
        end
      end
      GM_AW: begin
        if (aw_hs_s) begin
          state_d   = GM_WDATA;
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = 1'b1;
        end
      end
      GM_WDATA: begin
        if (w_hs_s) begin
          if (last_beat_s) begin
            state_d  = GM_BRESP;
            bready_d = 1'b1;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end else begin
          state_d = GM_WDATA;
        end
      end
      GM_BRESP: begin
        if (b_hs_s) begin
          if (m0_bid != MST_ID) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          state_d  = GM_IDLE;
          bready_d = 1'b0;
          done_d   = 1'b1;
        end else if (wd_fire_s) begin
          err_d    = 1'b1;
          state_d  = GM_IDLE;
          bready_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          bready_d = 1'b1;
        end
      end
      default: begin
        state_d   = GM_IDLE;
        arvalid_d = 1'b0;
        awvalid_d = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  // Reset drops any in-flight burst; the slave must be recovered externally
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q   <= GM_IDLE;
      addr_q    <= {GMEM_ADDR_W{1'b0}};
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_gmem_burst_master.sv
// Randomized bench for gmem_burst_master: transaction-phase model plus per-cycle compare process.
module tb_gmem_burst_master;
  import fcpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst, req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [7:0] req_len;
  logic [63:0] wd_data, rd_data, m0_rdata, m0_wdata;
  logic [7:0] wd_strb, m0_wstrb, m0_arlen, m0_awlen;
  logic wd_valid, wd_ready, rd_last, rd_valid, rd_ready, done, err;
  logic [3:0] m0_arid, m0_rid, m0_awid, m0_bid;
  logic [31:0] m0_araddr, m0_awaddr;
  logic [2:0] m0_arsize, m0_awsize;
  logic [1:0] m0_arburst, m0_awburst;
  logic m0_arvalid, m0_arready, m0_rlast, m0_rvalid, m0_rready;
  logic m0_awvalid, m0_awready, m0_wlast, m0_wvalid, m0_wready, m0_bvalid, m0_bready;

  gmem_burst_master dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .wd_data(wd_data), .wd_strb(wd_strb),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .done(done), .err(err),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid),
    .m0_rready(m0_rready), .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen),
    .m0_awsize(m0_awsize), .m0_awburst(m0_awburst), .m0_awvalid(m0_awvalid),
    .m0_awready(m0_awready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_bid(m0_bid), .m0_bvalid(m0_bvalid),
    .m0_bready(m0_bready)
  );

  // Phase of the single outstanding transaction as seen from outside the master
  typedef enum {P_IDLE, P_AR, P_R, P_AW, P_W, P_B} phase_t;
  phase_t ph = P_IDLE;
  logic [31:0] m_addr;
  int m_len, m_beat;
  bit m_done, m_err;
  int n_pass = 0, n_total = 0;
  int dut_rcnt, dut_wcnt;
  bit chk_en = 0, no_bp = 0, force_ff = 0, inj_bid = 0;
  int early = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // Advance the model by the handshakes that the previous cycle's inputs allow
  task automatic model_update();
    if (nrst) begin
      ph = P_IDLE; m_err = 0; m_done = 0;
    end else begin
      m_done = 0;
      case (ph)
        P_IDLE: if (req_valid) begin
          m_addr = req_addr + 32'h1000_0000; m_len = int'(req_len); m_beat = 0;
          ph = req_we ? P_AW : P_AR;
        end
        P_AR: if (m0_arready) ph = P_R;
        P_R: if (m0_rvalid && rd_ready) begin
          if (m0_rid != 4'd0 || m0_rlast != (m_beat == m_len)) m_err = 1;
          if (m0_rlast) begin
            if (early < 0) chk("rbeats", 64'(dut_rcnt), 64'(m_len + 1));
            ph = P_IDLE; m_done = 1;
          end else if (m_beat < 255) m_beat++;
        end
        P_AW: if (m0_awready) ph = P_W;
        P_W: if (wd_valid && m0_wready) begin
          if (m_beat == m_len) begin
            chk("wbeats", 64'(dut_wcnt), 64'(m_len + 1));
            ph = P_B;
          end else m_beat++;
        end
        P_B: if (m0_bvalid) begin
          if (m0_bid != 4'd0) m_err = 1;
          ph = P_IDLE; m_done = 1;
        end
        default: ph = P_IDLE;
      endcase
    end
  endtask

  task automatic drive_slave();
    m0_arready = no_bp ? 1'b1 : 1'($urandom_range(0, 1));
    m0_awready = no_bp ? 1'b1 : 1'($urandom_range(0, 1));
    m0_wready  = no_bp ? 1'b1 : ($urandom_range(0, 3) != 0);
    rd_ready   = no_bp ? 1'b1 : ($urandom_range(0, 3) != 0);
    m0_rvalid  = no_bp ? 1'b1 : ($urandom_range(0, 3) != 0);
    wd_valid   = no_bp ? 1'b1 : ($urandom_range(0, 3) != 0);
    m0_bvalid  = no_bp ? 1'b1 : ($urandom_range(0, 2) == 0);
    m0_rdata   = {$urandom(), $urandom()};
    wd_data    = {$urandom(), $urandom()};
    wd_strb    = force_ff ? 8'hFF : 8'($urandom());
    m0_bid     = inj_bid ? 4'd1 : 4'd0;
    if (ph == P_R) begin
      m0_rid   = 4'd0;
      m0_rlast = (early >= 0) ? (m_beat == early) : (m_beat == m_len);
    end else begin
      m0_rid   = 4'($urandom_range(0, 15));
      m0_rlast = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    drive_slave();
    req_valid = 1'b0;
  endtask

  task automatic start_req(input bit we, input logic [31:0] a, input logic [7:0] l);
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = l;
    dut_rcnt = 0; dut_wcnt = 0;
    tick();
  endtask

  task automatic run_to_idle(input int budget);
    int n = 0;
    while (ph != P_IDLE && n < budget) begin tick(); n++; end
    if (ph != P_IDLE) begin
      n_total++;
      $display("FAIL timeout: transaction still in phase %0d after %0d cycles", ph, budget);
    end
  endtask

  // Compare process: every output is a function of the model phase and bench-driven inputs
  always @(negedge clk) begin
    if (chk_en) begin
      if (rd_valid && rd_ready) dut_rcnt++;
      if (m0_wvalid && m0_wready) dut_wcnt++;
      chk("req_ready", 64'(req_ready), 64'(ph == P_IDLE));
      chk("arvalid", 64'(m0_arvalid), 64'(ph == P_AR));
      chk("awvalid", 64'(m0_awvalid), 64'(ph == P_AW));
      if (ph == P_AR) begin
        chk("araddr", 64'(m0_araddr), 64'(m_addr));
        chk("arlen", 64'(m0_arlen), 64'(m_len));
        chk("arid", 64'(m0_arid), 64'd0);
        chk("arsize", 64'(m0_arsize), 64'd3);
      end
      if (ph == P_AW) begin
        chk("awaddr", 64'(m0_awaddr), 64'(m_addr));
        chk("awlen", 64'(m0_awlen), 64'(m_len));
        chk("awid", 64'(m0_awid), 64'd0);
      end
      chk("rd_valid", 64'(rd_valid), 64'(ph == P_R && m0_rvalid));
      chk("rready", 64'(m0_rready), 64'(ph == P_R && rd_ready));
      if (ph == P_R) begin
        chk("rd_data", rd_data, m0_rdata);
        chk("rd_last", 64'(rd_last), 64'(m0_rlast));
      end
      chk("wvalid", 64'(m0_wvalid), 64'(ph == P_W && wd_valid));
      chk("wd_ready", 64'(wd_ready), 64'(ph == P_W && m0_wready));
      if (ph == P_W) begin
        chk("wdata", m0_wdata, wd_data);
        chk("wstrb", 64'(m0_wstrb), 64'(wd_strb));
        chk("wlast", 64'(m0_wlast), 64'(m_beat == m_len));
      end
      chk("bready", 64'(m0_bready), 64'(ph == P_B));
      chk("done", 64'(done), 64'(m_done));
      chk("err", 64'(err), 64'(m_err));
    end
  end

  initial begin
    nrst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_len = 8'd0;
    drive_slave();
    tick(); tick();
    nrst = 1'b0; chk_en = 1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_bready", 64'(m0_bready), 64'd0);

    // Read addr 0x40 len 3, no backpressure
    no_bp = 1;
    start_req(1'b0, 32'h40, 8'd3);
    @(negedge clk);
    chk("lit_araddr", 64'(m0_araddr), 64'h1000_0040);
    chk("lit_arlen", 64'(m0_arlen), 64'd3);
    run_to_idle(100);
    @(negedge clk);
    chk("lit_rbeats", 64'(dut_rcnt), 64'd4);
    chk("lit_rd_done", 64'(done), 64'd1);
    chk("lit_rd_err", 64'(err), 64'd0);

    // Single-beat write with full strobes
    force_ff = 1;
    start_req(1'b1, 32'h80, 8'd0);
    @(negedge clk);
    chk("lit_awlen", 64'(m0_awlen), 64'd0);
    chk("lit_awaddr", 64'(m0_awaddr), 64'h1000_0080);
    tick();
    @(negedge clk);
    chk("lit_wlast", 64'(m0_wlast), 64'd1);
    chk("lit_wstrb", 64'(m0_wstrb), 64'hFF);
    tick();
    @(negedge clk);
    chk("lit_bready", 64'(m0_bready), 64'd1);
    run_to_idle(20);
    @(negedge clk);
    chk("lit_wr_done", 64'(done), 64'd1);
    force_ff = 0; no_bp = 0;

    // Randomized traffic with backpressure on every channel
    for (int i = 0; i < 40; i++) begin
      int l;
      l = (i % 8 == 7) ? int'($urandom_range(8, 40)) : int'($urandom_range(0, 7));
      start_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 3, 8'(l));
      run_to_idle(20 * (l + 1) + 100);
    end
    start_req(1'b1, 32'h200, 8'd255);
    run_to_idle(6000);
    start_req(1'b0, 32'h208, 8'd255);
    run_to_idle(6000);

    // Reset during the second write beat
    no_bp = 1;
    start_req(1'b1, 32'h100, 8'd3);
    tick(); tick();
    nrst = 1'b1;
    tick();
    nrst = 1'b0;
    @(negedge clk);
    chk("lit_rst_wvalid", 64'(m0_wvalid), 64'd0);
    chk("lit_rst_req_ready", 64'(req_ready), 64'd1);

    // Wrong BID sets sticky err
    inj_bid = 1;
    start_req(1'b1, 32'h20, 8'd1);
    run_to_idle(50);
    inj_bid = 0;
    @(negedge clk);
    chk("lit_bid_err", 64'(err), 64'd1);
    tick();
    @(negedge clk);
    chk("lit_err_sticky", 64'(err), 64'd1);
    nrst = 1'b1; tick(); nrst = 1'b0;

    // Early rlast on beat 2 of a 4-beat read
    early = 1;
    start_req(1'b0, 32'h60, 8'd3);
    run_to_idle(50);
    early = -1;
    @(negedge clk);
    chk("lit_early_err", 64'(err), 64'd1);
    chk("lit_early_done", 64'(done), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
